// File: rtl/dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_queue_if
// Brief   : Decode-side, issue-side and status bundle for dispatch_queue.
// Revision: 1.0 - initial release
// ============================================================================
interface dispatch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int CTRL_W = 24,
  parameter int PC_W   = 64,
  parameter int SEQ_W  = 6,
  parameter int MAX_BR = 2
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int BRC_W = $clog2(MAX_BR) + 1;

  logic              flush_i;
  logic              dec_valid_i;
  logic              dec_ready_o;
  logic [CTRL_W-1:0] dec_ctrl_i;
  logic [3:0]        dec_cmd_type_i;
  logic [PC_W-1:0]   dec_pc_i;
  logic [CTRL_W-1:0] issue_ctrl_o;
  logic [3:0]        issue_cmd_type_o;
  logic [PC_W-1:0]   issue_pc_o;
  logic [SEQ_W-1:0]  issue_seq_o;
  logic              alu_valid_o;
  logic              alu_ready_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic              br_valid_o;
  logic              br_ready_i;
  logic              br_resolve_i;
  logic [OCC_W-1:0]  occupancy_o;
  logic [BRC_W-1:0]  br_count_o;

  // master is the queue itself; slave is the surrounding pipeline
  modport master (
    input  flush_i, dec_valid_i, dec_ctrl_i, dec_cmd_type_i, dec_pc_i,
           alu_ready_i, mem_ready_i, br_ready_i, br_resolve_i,
    output dec_ready_o, issue_ctrl_o, issue_cmd_type_o, issue_pc_o, issue_seq_o,
           alu_valid_o, mem_valid_o, br_valid_o, occupancy_o, br_count_o
  );

  modport slave (
    output flush_i, dec_valid_i, dec_ctrl_i, dec_cmd_type_i, dec_pc_i,
           alu_ready_i, mem_ready_i, br_ready_i, br_resolve_i,
    input  dec_ready_o, issue_ctrl_o, issue_cmd_type_o, issue_pc_o, issue_seq_o,
           alu_valid_o, mem_valid_o, br_valid_o, occupancy_o, br_count_o
  );
endinterface
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_queue
// Brief   : In-order FWFT op buffer steering the head op to ALU/MEM/BR units.
// Revision: 1.0 - initial release
// ============================================================================
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int CTRL_W = 24,
  parameter int PC_W   = 64,
  parameter int SEQ_W  = 6,
  parameter int MAX_BR = 2
) (
  input  logic               clk,
  input  logic               reset,
  dispatch_queue_if.master   bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int BRC_W = $clog2(MAX_BR) + 1;

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_MEM = 2'd1;
  localparam logic [1:0] CLS_BR  = 2'd2;
  localparam logic [1:0] CLS_ILL = 2'd3;

  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [3:0]        type_q [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [OCC_W-1:0]  occ;
  logic [BRC_W-1:0]  br_cnt;
  logic [SEQ_W-1:0]  seq;

  logic [3:0]        head_type;
  logic [1:0]        head_cls;
  logic              not_empty;
  logic              live;
  logic              push;
  logic              pop;
  logic              dispatch;
  logic              br_dispatch;
  logic              br_release;

  assign head_type = type_q[head];

  always_comb begin
    head_cls = CLS_ILL;
    case (head_type)
      4'd0:                         head_cls = CLS_ALU;
      4'd1, 4'd9:                   head_cls = CLS_MEM;
      4'd2, 4'd4, 4'd6, 4'd7, 4'd8: head_cls = CLS_BR;
      default:                      head_cls = CLS_ILL;
    endcase
  end

  // flush masks every handshake in its own cycle
  assign not_empty = (occ != '0);
  assign live      = not_empty & ~bus.flush_i;

  assign bus.alu_valid_o = live & (head_cls == CLS_ALU);
  assign bus.mem_valid_o = live & (head_cls == CLS_MEM);
  assign bus.br_valid_o  = live & (head_cls == CLS_BR) & (br_cnt < BRC_W'(MAX_BR));

  assign br_dispatch = bus.br_valid_o & bus.br_ready_i;
  assign dispatch    = (bus.alu_valid_o & bus.alu_ready_i) |
                       (bus.mem_valid_o & bus.mem_ready_i) |
                       br_dispatch;
  // illegal commandTypes drain in one cycle without consuming a tag
  assign pop         = dispatch | (live & (head_cls == CLS_ILL));

  assign bus.dec_ready_o = (occ < OCC_W'(DEPTH)) & ~bus.flush_i;
  assign push            = bus.dec_valid_i & bus.dec_ready_o;
  assign br_release      = bus.br_resolve_i & (br_cnt != '0);

  assign bus.issue_ctrl_o     = not_empty ? ctrl_q[head] : '0;
  assign bus.issue_cmd_type_o = not_empty ? head_type    : '0;
  assign bus.issue_pc_o       = not_empty ? pc_q[head]   : '0;
  assign bus.issue_seq_o      = seq;
  assign bus.occupancy_o      = occ;
  assign bus.br_count_o       = br_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      occ    <= '0;
      br_cnt <= '0;
      seq    <= '0;
    end else if (bus.flush_i) begin
      head   <= '0;
      tail   <= '0;
      occ    <= '0;
      br_cnt <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
      if (dispatch) seq <= seq + SEQ_W'(1);
      if (br_dispatch && !br_release)      br_cnt <= br_cnt + BRC_W'(1);
      else if (!br_dispatch && br_release) br_cnt <= br_cnt - BRC_W'(1);
    end
  end

  // payload storage needs no reset: outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_q[tail] <= bus.dec_ctrl_i;
      type_q[tail] <= bus.dec_cmd_type_i;
      pc_q[tail]   <= bus.dec_pc_i;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_dispatch_queue
// Brief   : Directed and random stimulus against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;
  localparam int DEPTH  = 4;
  localparam int CTRL_W = 24;
  localparam int PC_W   = 64;
  localparam int SEQ_W  = 6;
  localparam int MAX_BR = 2;

  logic clk = 1'b0;
  logic reset;

  dispatch_queue_if #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .PC_W(PC_W),
                      .SEQ_W(SEQ_W), .MAX_BR(MAX_BR)) bus ();

  dispatch_queue #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .PC_W(PC_W),
                   .SEQ_W(SEQ_W), .MAX_BR(MAX_BR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [3:0]        typ;
    logic [PC_W-1:0]   pc;
  } op_t;

  op_t q[$];
  int  m_br  = 0;
  int  m_seq = 0;
  int  errors = 0;
  int  checks = 0;

  bit  e_pop, e_push, e_disp, e_brd, e_flush, e_res;
  op_t e_op;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = ALU, 1 = MEM, 2 = BR, 3 = illegal
  function automatic int unit_of(logic [3:0] t);
    if (t == 4'd0) return 0;
    if (t inside {4'd1, 4'd9}) return 1;
    if (t inside {4'd2, 4'd4, 4'd6, 4'd7, 4'd8}) return 2;
    return 3;
  endfunction

  task automatic drive(bit v, logic [3:0] t, bit ar, bit mr, bit brr, bit res, bit fl);
    bus.dec_valid_i    = v;
    bus.dec_cmd_type_i = t;
    bus.dec_ctrl_i     = CTRL_W'($urandom);
    bus.dec_pc_i       = {$urandom, $urandom};
    bus.alu_ready_i    = ar;
    bus.mem_ready_i    = mr;
    bus.br_ready_i     = brr;
    bus.br_resolve_i   = res;
    bus.flush_i        = fl;
  endtask

  task automatic check_and_predict();
    bit ne, ea, em, eb;
    int u;
    ne = (q.size() != 0);
    e_flush = bus.flush_i;
    u  = ne ? unit_of(q[0].typ) : 4;
    ea = ne && !e_flush && (u == 0);
    em = ne && !e_flush && (u == 1);
    eb = ne && !e_flush && (u == 2) && (m_br < MAX_BR);
    chk("dec_ready", 64'(bus.dec_ready_o), 64'((q.size() < DEPTH) && !e_flush));
    chk("occupancy", 64'(bus.occupancy_o), 64'(q.size()));
    chk("br_count",  64'(bus.br_count_o),  64'(m_br));
    chk("alu_valid", 64'(bus.alu_valid_o), 64'(ea));
    chk("mem_valid", 64'(bus.mem_valid_o), 64'(em));
    chk("br_valid",  64'(bus.br_valid_o),  64'(eb));
    chk("issue_seq", 64'(bus.issue_seq_o), 64'(m_seq));
    if (ea || em || eb) begin
      chk("issue_ctrl", 64'(bus.issue_ctrl_o),     64'(q[0].ctrl));
      chk("issue_type", 64'(bus.issue_cmd_type_o), 64'(q[0].typ));
      chk("issue_pc",   64'(bus.issue_pc_o),       64'(q[0].pc));
    end
    e_disp = (ea && bus.alu_ready_i) || (em && bus.mem_ready_i) || (eb && bus.br_ready_i);
    e_brd  = eb && bus.br_ready_i;
    e_pop  = e_disp || (ne && !e_flush && (u == 3));
    e_push = bus.dec_valid_i && (q.size() < DEPTH) && !e_flush;
    e_res  = bus.br_resolve_i;
    e_op   = '{ctrl: bus.dec_ctrl_i, typ: bus.dec_cmd_type_i, pc: bus.dec_pc_i};
  endtask

  task automatic model_update();
    int old_br;
    if (e_flush) begin
      q.delete();
      m_br = 0;
      return;
    end
    if (e_pop)  q.delete(0);
    if (e_push) q.push_back(e_op);
    if (e_disp) m_seq = (m_seq + 1) % (1 << SEQ_W);
    old_br = m_br;
    if (e_brd) m_br++;
    if (e_res && old_br > 0) m_br--;
  endtask

  task automatic step();
    #1;
    check_and_predict();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_occupancy", 64'(bus.occupancy_o),      64'd0);
    chk("rst_br_count",  64'(bus.br_count_o),       64'd0);
    chk("rst_dec_ready", 64'(bus.dec_ready_o),      64'd1);
    chk("rst_valids",    64'({bus.alu_valid_o, bus.mem_valid_o, bus.br_valid_o}), 64'd0);
    chk("rst_seq",       64'(bus.issue_seq_o),      64'd0);
    chk("rst_ctrl",      64'(bus.issue_ctrl_o),     64'd0);
    chk("rst_type",      64'(bus.issue_cmd_type_o), 64'd0);
    chk("rst_pc",        64'(bus.issue_pc_o),       64'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_br  = 0;
    m_seq = 0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);

    // ALU, MEM, BR back to back with every unit ready
    drive(1, 4'd0, 1, 1, 1, 0, 0); step();
    drive(1, 4'd1, 1, 1, 1, 0, 0); step();
    drive(1, 4'd8, 1, 1, 1, 0, 0); step();
    drive(0, 4'd0, 1, 1, 1, 0, 0); step(); step(); step();
    chk("t1_br_count", 64'(bus.br_count_o), 64'd1);
    drive(0, 4'd0, 0, 0, 0, 1, 0); step();
    step();
    step();

    // fill to full with no unit ready, then pop against a full queue
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'd0, 0, 0, 0, 0, 0); step();
    end
    drive(1, 4'd0, 1, 0, 0, 0, 0); step();
    drive(1, 4'd0, 0, 0, 0, 0, 0); step();
    drive(0, 4'd0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'd0, 1, 0, 0, 0, 0); step();
    end

    // branch limit
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd4, 0, 0, 1, 0, 0); step();
    end
    drive(0, 4'd0, 0, 0, 1, 0, 0); step(); step(); step();
    drive(0, 4'd0, 0, 0, 1, 1, 0); step();
    drive(0, 4'd0, 0, 0, 1, 0, 0); step(); step();
    chk("t3_br_count", 64'(bus.br_count_o), 64'd2);

    // illegal head drains silently
    drive(1, 4'd5, 1, 0, 0, 0, 0); step();
    drive(1, 4'd0, 1, 0, 0, 0, 0); step();
    drive(0, 4'd0, 1, 0, 0, 0, 0); step(); step();

    // flush with three ops queued and two branches outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd0, 0, 0, 0, 0, 0); step();
    end
    drive(1, 4'd0, 1, 1, 1, 1, 1); step();
    drive(0, 4'd0, 0, 0, 0, 0, 0); step(); step();

    // asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd1, 0, 0, 0, 0, 0); step();
    end
    drive(0, 4'd0, 0, 0, 0, 0, 0); step();
    chk("pre_reset_occupancy", 64'(bus.occupancy_o), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 3) != 0, 4'($urandom % 16),
            ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
            (m_br > 0) && (($urandom % 4) == 0),
            ($urandom % 25) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
